sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO; successor to the fixed 8-bit shift-register FIFO.

---
 rtl/soc_fifo_pkg.sv | 27 ++
 rtl/fifo_mem_2p.sv | 27 ++
 rtl/sync_fifo_param.sv | 114 +++++++++++
 tb/tb_sync_fifo_param.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO: default widths, clog2 and the
// pointer wrap function.
package soc_fifo_pkg;

  localparam int unsigned DefDataW   = 8;
  localparam int unsigned DefDepth   = 8;
  localparam int unsigned DefAfLevel = 6;
  localparam int unsigned DefAeLevel = 2;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Two-port register array: synchronous write, asynchronous read, no reset on the storage.
module fifo_mem_2p
  import soc_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned ADDR_W = clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock circular-buffer FIFO with occupancy, threshold flags and
// reject pulses. Define SYNC_FIFO_FWFT_EN for first-word fall-through reads.
module sync_fifo_param
  import soc_fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned DEPTH    = DefDepth,
  parameter int unsigned AF_LEVEL = DefAfLevel,
  parameter int unsigned AE_LEVEL = DefAeLevel,
  parameter int unsigned CNT_W    = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              wwe,
  input  logic              rwe,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned PtrW = clog2(DEPTH);
  localparam logic [CNT_W-1:0] DepthC = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AfC    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AeC    = CNT_W'(AE_LEVEL);

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, empty_q, af_q, ae_q, ovf_q, udf_q;
  logic              wr_ok, rd_ok;
  logic [DATA_W-1:0] mem_rdata;

  always_comb begin
    rd_ok = rwe & ~empty_q;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    wr_ok = wwe & (~full_q | rd_ok);
    wr_ptr_d = wr_ok ? PtrW'(next_ptr(32'(wr_ptr_q), DEPTH)) : wr_ptr_q;
    rd_ptr_d = rd_ok ? PtrW'(next_ptr(32'(rd_ptr_q), DEPTH)) : rd_ptr_q;
    count_d  = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DepthC);
      empty_q  <= (count_d == '0);
      af_q     <= (count_d >= AfC);
      ae_q     <= (count_d <= AeC);
      ovf_q    <= wwe & ~wr_ok;
      udf_q    <= rwe & ~rd_ok;
    end
  end

  fifo_mem_2p #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(PtrW)
  ) u_mem (
    .clk_i  (clk),
    .we_i   (wr_ok),
    .waddr_i(wr_ptr_q),
    .wdata_i(din),
    .raddr_i(rd_ptr_q),
    .rdata_o(mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Gating on empty keeps the reset value at 0 without resetting the array.
  assign dout = empty_q ? '0 : mem_rdata;
`else
  logic [DATA_W-1:0] dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (rd_ok) begin
      dout_q <= mem_rdata;
    end
  end

  assign dout = dout_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a DEPTH=8 and a DEPTH=5 instance share stimulus and are
// compared against queue-based reference models.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       wwe = 1'b0;
  logic       rwe = 1'b0;

  logic [7:0] dout8, dout5;
  logic       full8, empty8, af8, ae8, ovf8, udf8;
  logic       full5, empty5, af5, ae5, ovf5, udf5;
  logic [3:0] count8;
  logic [2:0] count5;

  int errors = 0;
  int checks = 0;

  int unsigned dep  [2] = '{8, 5};
  int unsigned af_l [2] = '{6, 4};
  int unsigned ae_l [2] = '{2, 1};

  logic [7:0] mq [2][$];
  logic [7:0] m_dout [2];
  logic       m_ovf [2];
  logic       m_udf [2];

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut8 (
    .clk(clk), .rst_n(rst_n), .din(din), .wwe(wwe), .rwe(rwe), .dout(dout8),
    .full(full8), .empty(empty8), .almost_full(af8), .almost_empty(ae8),
    .count(count8), .overflow(ovf8), .underflow(udf8)
  );

  sync_fifo_param #(
    .DATA_W(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)
  ) dut5 (
    .clk(clk), .rst_n(rst_n), .din(din), .wwe(wwe), .rwe(rwe), .dout(dout5),
    .full(full5), .empty(empty5), .almost_full(af5), .almost_empty(ae5),
    .count(count5), .overflow(ovf5), .underflow(udf5)
  );

  function automatic int unsigned o_count(int i);
    return (i == 0) ? 32'(count8) : 32'(count5);
  endfunction

  function automatic logic [7:0] o_dout(int i);
    return (i == 0) ? dout8 : dout5;
  endfunction

  function automatic logic [5:0] o_flags(int i);
    return (i == 0) ? {full8, empty8, af8, ae8, ovf8, udf8}
                    : {full5, empty5, af5, ae5, ovf5, udf5};
  endfunction

  function automatic logic [5:0] e_flags(int i);
    int unsigned n;
    n = mq[i].size();
    return {n == dep[i], n == 0, n >= af_l[i], n <= ae_l[i], m_ovf[i], m_udf[i]};
  endfunction

  function automatic logic [7:0] e_dout(int i);
`ifdef SYNC_FIFO_FWFT_EN
    return (mq[i].size() > 0) ? mq[i][0] : 8'h00;
`else
    return m_dout[i];
`endif
  endfunction

  // Head word is don't-care while empty in fall-through mode.
  function automatic logic [7:0] dmask(int i);
`ifdef SYNC_FIFO_FWFT_EN
    return (mq[i].size() > 0) ? 8'hFF : 8'h00;
`else
    return 8'hFF;
`endif
  endfunction

  task automatic step(input logic w, input logic r, input logic [7:0] d);
    bit rd_ok, wr_ok;
    @(negedge clk);
    wwe = w;
    rwe = r;
    din = d;
    for (int i = 0; i < 2; i++) begin
      rd_ok = r && (mq[i].size() > 0);
      wr_ok = w && ((mq[i].size() < dep[i]) || rd_ok);
      if (rd_ok) m_dout[i] = mq[i].pop_front();
      if (wr_ok) mq[i].push_back(d);
      m_ovf[i] = w && !wr_ok;
      m_udf[i] = r && !rd_ok;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    wwe = 1'b0;
    rwe = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_dout[i] = 8'h00;
      m_ovf[i] = 1'b0;
      m_udf[i] = 1'b0;
    end
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    release_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (o_count(i) !== 0) begin
        errors++;
        $display("FAIL reset_count inst%0d got %0d want 0", i, o_count(i));
      end
      checks++;
      if (o_flags(i) !== 6'b010100) begin
        errors++;
        $display("FAIL reset_flags inst%0d got %b want 010100", i, o_flags(i));
      end
      checks++;
      if (o_dout(i) !== 8'h00) begin
        errors++;
        $display("FAIL reset_dout inst%0d got %h want 00", i, o_dout(i));
      end
    end
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, 1'b0, 8'(k * 17));
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (o_count(i) !== 32'(mq[i].size())) begin
          errors++;
          $display("FAIL fill_count inst%0d wr%0d got %0d want %0d", i, k, o_count(i),
                   mq[i].size());
        end
        checks++;
        if (o_flags(i) !== e_flags(i)) begin
          errors++;
          $display("FAIL fill_flags inst%0d wr%0d got %b want %b", i, k, o_flags(i),
                   e_flags(i));
        end
        checks++;
        if ((o_dout(i) & dmask(i)) !== (e_dout(i) & dmask(i))) begin
          errors++;
          $display("FAIL fill_dout inst%0d wr%0d got %h want %h", i, k, o_dout(i), e_dout(i));
        end
      end
    end
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (o_flags(0) !== e_flags(0)) begin
      errors++;
      $display("FAIL ovf_clear got %b want %b", o_flags(0), e_flags(0));
    end
  endtask

  task automatic test_drain();
    for (int k = 1; k <= 9; k++) begin
      step(1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ((o_dout(i) & dmask(i)) !== (e_dout(i) & dmask(i))) begin
          errors++;
          $display("FAIL drain_dout inst%0d rd%0d got %h want %h", i, k, o_dout(i), e_dout(i));
        end
        checks++;
        if (o_flags(i) !== e_flags(i)) begin
          errors++;
          $display("FAIL drain_flags inst%0d rd%0d got %b want %b", i, k, o_flags(i),
                   e_flags(i));
        end
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    release_reset();
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 8'(8'hC0 + k));
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 8'h00);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 8'(8'hD0 + k));
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ((o_dout(i) & dmask(i)) !== (e_dout(i) & dmask(i))) begin
          errors++;
          $display("FAIL wrap_dout inst%0d rd%0d got %h want %h", i, k, o_dout(i), e_dout(i));
        end
      end
    end
    checks++;
    if (o_count(1) !== 0) begin
      errors++;
      $display("FAIL wrap_count got %0d want 0", o_count(1));
    end
  endtask

  task automatic test_full_rw();
    apply_reset();
    release_reset();
    for (int k = 1; k <= 8; k++) step(1'b1, 1'b0, 8'(k * 17));
    step(1'b1, 1'b1, 8'hA5);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (o_flags(i) !== e_flags(i) || o_count(i) !== 32'(mq[i].size())) begin
        errors++;
        $display("FAIL full_rw inst%0d got flags %b cnt %0d want %b cnt %0d", i, o_flags(i),
                 o_count(i), e_flags(i), mq[i].size());
      end
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 8'h00);
      checks++;
      if ((o_dout(0) & dmask(0)) !== (e_dout(0) & dmask(0))) begin
        errors++;
        $display("FAIL full_rw_dout rd%0d got %h want %h", k, o_dout(0), e_dout(0));
      end
    end
  endtask

  task automatic test_empty_rw();
    apply_reset();
    release_reset();
    step(1'b1, 1'b1, 8'h5A);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (o_flags(i) !== e_flags(i) || o_count(i) !== 1) begin
        errors++;
        $display("FAIL empty_rw inst%0d got flags %b cnt %0d want %b cnt 1", i, o_flags(i),
                 o_count(i), e_flags(i));
      end
    end
    step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (o_dout(i) !== m_dout[i] && dmask(i) == 8'hFF) begin
        errors++;
        $display("FAIL empty_rw_dout inst%0d got %h want %h", i, o_dout(i), m_dout[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    release_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 8'(8'h60 + k));
    step(1'b0, 1'b1, 8'h00);
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (o_count(i) !== 0 || o_flags(i) !== 6'b010100 || o_dout(i) !== 8'h00) begin
        errors++;
        $display("FAIL mid_reset inst%0d got cnt %0d flags %b dout %h want 0 010100 00", i,
                 o_count(i), o_flags(i), o_dout(i));
      end
    end
    release_reset();
    step(1'b1, 1'b0, 8'h3C);
    step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ((o_dout(i) & dmask(i)) !== (e_dout(i) & dmask(i)) || o_count(i) !== 0) begin
        errors++;
        $display("FAIL post_reset inst%0d got dout %h cnt %0d want %h 0", i, o_dout(i),
                 o_count(i), e_dout(i));
      end
    end
  endtask

  task automatic test_random();
    int unsigned pw;
    apply_reset();
    release_reset();
    for (int k = 0; k < 600; k++) begin
      pw = ((k / 100) % 2 == 0) ? 75 : 25;
      step($urandom_range(0, 99) < pw, $urandom_range(0, 99) >= pw, 8'($urandom));
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (o_count(i) !== 32'(mq[i].size())) begin
          errors++;
          $display("FAIL rnd_count inst%0d step%0d got %0d want %0d", i, k, o_count(i),
                   mq[i].size());
        end
        checks++;
        if (o_flags(i) !== e_flags(i)) begin
          errors++;
          $display("FAIL rnd_flags inst%0d step%0d got %b want %b", i, k, o_flags(i),
                   e_flags(i));
        end
        checks++;
        if ((o_dout(i) & dmask(i)) !== (e_dout(i) & dmask(i))) begin
          errors++;
          $display("FAIL rnd_dout inst%0d step%0d got %h want %h", i, k, o_dout(i), e_dout(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_full_rw();
    test_empty_rw();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
